// File: rtl/uart_rx_framer_pkg.sv
// uart_rx_framer_pkg: shared UART receive state encodings and default bit timing
package uart_rx_framer_pkg;
    localparam int DEFAULT_BAUD_DIVISOR = 234;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO with extra-bit occupancy pointers
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_pop, do_push;
    always_comb begin
        empty = wr_ptr == rd_ptr;
        full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        head_data = empty ? 8'd0 : mem[rd_ptr[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART receiver with mid-bit sampling, byte FIFO and sticky error flags
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int BAUD_DIVISOR = DEFAULT_BAUD_DIVISOR,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_read,
    output logic       framing_error,
    output logic       overrun,
    input  logic       clear_errors
);
    localparam int CW = $clog2(BAUD_DIVISOR) + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIVISOR / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD = CW'(BAUD_DIVISOR - 1);
    rx_state_t state, state_n;
    logic [1:0] sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_count, bit_count_n;
    logic [7:0] shreg, shreg_n;
    logic rx_s, expired, stop_ok, fe_set, ov_set, pop, empty, full;
    assign rx_s = sync[1];
    assign rx_ready = !empty;
    always_comb begin
        state_n = state;
        expired = cnt == '0;
        cnt_n = expired ? cnt : cnt - CW'(1);
        bit_count_n = bit_count;
        shreg_n = shreg;
        stop_ok = 1'b0;
        fe_set = 1'b0;
        pop = rx_read && !empty;
        case (state)
            IDLE: if (!rx_s) begin
                cnt_n = HALF_LOAD;
                state_n = START;
            end
            START: if (expired) begin
                cnt_n = BIT_LOAD;
                bit_count_n = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (expired) begin
                shreg_n = {rx_s, shreg[7:1]};
                bit_count_n = bit_count + 3'd1;
                cnt_n = BIT_LOAD;
                state_n = (bit_count == 3'd7) ? STOP : DATA;
            end
            STOP: if (expired) begin
                stop_ok = rx_s;
                fe_set = !rx_s;
                state_n = rx_s ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ov_set = stop_ok && full && !pop;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sync <= 2'b11;
            cnt <= '0;
            bit_count <= '0;
            shreg <= '0;
            framing_error <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            sync <= {sync[0], rx};
            cnt <= cnt_n;
            bit_count <= bit_count_n;
            shreg <= shreg_n;
            framing_error <= fe_set || (framing_error && !clear_errors);
            overrun <= ov_set || (overrun && !clear_errors);
        end
    end
    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(stop_ok),
        .push_data(shreg),
        .pop(rx_read),
        .head_data(rx_data),
        .empty(empty),
        .full(full)
    );
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed scoreboard bench for the UART receive framer
module tb_uart_rx_framer;
    localparam int BAUD = 8;
    logic clk = 1'b0, reset = 1'b1, rx = 1'b1, rx_read = 1'b0, clear_errors = 1'b0;
    logic [7:0] rx_data;
    logic rx_ready, framing_error, overrun;
    logic ready_d = 1'b0;
    int tests = 0, fails = 0, cyc = 0, start_cyc = 0, ready_cyc = 0;
    logic [7:0] exp_q [$];

    uart_rx_framer #(.BAUD_DIVISOR(BAUD), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .rx_read(rx_read),
        .framing_error(framing_error),
        .overrun(overrun),
        .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        ready_d <= rx_ready;
        if (rx_ready && !ready_d) ready_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit expect_push);
        if (expect_push) exp_q.push_back(d);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic read_byte();
        check("ready_before_read", rx_ready, 1);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: observed a read, expected no pending byte");
        end else check("rx_data", rx_data, exp_q.pop_front());
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", rx_ready, 0);
        check("reset_data", rx_data, 0);
        check("reset_fe", framing_error, 0);
        check("reset_ov", overrun, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_byte(8'h55, 1'b1, 1'b1);
        check("lat_55", (ready_cyc - start_cyc >= 77) && (ready_cyc - start_cyc <= 80), 1);
        fork
            send_byte(8'hA3, 1'b1, 1'b1);
            read_byte();
        join
        check("lat_a3", (ready_cyc - start_cyc >= 77) && (ready_cyc - start_cyc <= 80), 1);
        read_byte();
        check("t1_empty", rx_ready, 0);
        check("t1_fe", framing_error, 0);
        check("t1_ov", overrun, 0);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch_ready", rx_ready, 0);
        check("glitch_fe", framing_error, 0);
        check("glitch_ov", overrun, 0);
        check("glitch_idle", dut.state, 0);
        send_byte(8'h3C, 1'b1, 1'b1);
        read_byte();
        check("t2_empty", rx_ready, 0);

        send_byte(8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("break_fe", framing_error, 1);
        check("break_ready", rx_ready, 0);
        check("break_ov", overrun, 0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("break_no_frame", rx_ready, 0);
        send_byte(8'h12, 1'b1, 1'b1);
        read_byte();
        check("fe_sticky", framing_error, 1);
        pulse_clear();
        check("fe_cleared", framing_error, 0);

        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, i <= 4);
        check("ov_set", overrun, 1);
        check("ov_fe", framing_error, 0);
        pulse_clear();
        check("ov_cleared", overrun, 0);
        repeat (4) read_byte();
        check("t4_empty", rx_ready, 0);

        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b1);
        check("t5_full_ov", overrun, 0);
        fork
            send_byte(8'h15, 1'b1, 1'b1);
            begin
                repeat (78) @(negedge clk);
                read_byte();
            end
        join
        check("t5_no_ov", overrun, 0);
        repeat (4) read_byte();
        check("t5_empty", rx_ready, 0);

        send_byte(8'h77, 1'b1, 1'b1);
        send_byte(8'h99, 1'b0, 1'b0);
        check("pre_reset_fe", framing_error, 1);
        check("pre_reset_ready", rx_ready, 1);
        fork
            send_byte(8'hF5, 1'b1, 1'b0);
            begin
                repeat (44) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("mid_reset_ready", rx_ready, 0);
                check("mid_reset_data", rx_data, 0);
                check("mid_reset_fe", framing_error, 0);
                check("mid_reset_ov", overrun, 0);
                exp_q.delete();
            end
        join
        repeat (20) @(negedge clk);
        check("post_reset_no_push", rx_ready, 0);
        check("post_reset_fe", framing_error, 0);
        send_byte(8'hE7, 1'b1, 1'b1);
        read_byte();
        check("t6_empty", rx_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
